// File: rtl/data_mem_ctrl_if.sv
// rtl/data_mem_ctrl_if.sv - load/store bus between execute stage and data memory
interface data_mem_ctrl_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] rsData;
    logic [DATA_W-1:0] rtData;
    logic [3:0]        offset;
    logic              enable;
    logic              wr;
    logic [15:0]       target_addr;
    logic [DATA_W-1:0] data_out;

    modport master (
        output rsData, rtData, offset, enable, wr,
        input  target_addr, data_out
    );

    modport slave (
        input  rsData, rtData, offset, enable, wr,
        output target_addr, data_out
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - WISC data-memory stage: effective address plus word memory
module data_mem_ctrl #(
    parameter int WORD_AW = 8,
    parameter int DATA_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    data_mem_ctrl_if.slave   bus
);
    localparam int DEPTH = 2 ** WORD_AW;

    logic [15:0]        addr;
    logic [WORD_AW-1:0] word_idx;
    logic [DATA_W-1:0]  mem [DEPTH];
    logic               rd_en;

    // Byte address is forced even; offset counts words, so it is doubled.
    assign addr        = (bus.rsData & 16'hFFFE) + {{11{bus.offset[3]}}, bus.offset, 1'b0};
    assign word_idx    = WORD_AW'(addr >> 1);
    assign bus.target_addr = addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (bus.enable && bus.wr) begin
            mem[word_idx] <= bus.rtData;
        end
    end

    // Reads are gated by rst_n so the output is zero for the whole reset window.
    assign rd_en        = rst_n && bus.enable && !bus.wr;
    assign bus.data_out = rd_en ? mem[word_idx] : '0;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - randomized self-checking bench for data_mem_ctrl
module tb_data_mem_ctrl;
    localparam int WORD_AW = 8;
    localparam int DEPTH   = 2 ** WORD_AW;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;
    int   ref_mem [DEPTH];

    data_mem_ctrl_if #(.DATA_W(16)) bus ();

    data_mem_ctrl #(.WORD_AW(WORD_AW), .DATA_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ref_addr(input int rs, input int off);
        int s;
        s = (off >= 8) ? off - 16 : off;
        return ((rs - (rs % 2)) + 2 * s + 65536) % 65536;
    endfunction

    function automatic int ref_idx(input int a);
        return (a / 2) % DEPTH;
    endfunction

    function automatic int ref_read(input int rs, input int off, input bit en, input bit w, input bit rn);
        if (rn && en && !w) return ref_mem[ref_idx(ref_addr(rs, off))];
        return 0;
    endfunction

    task automatic drive(input int rs, input int off, input int rt, input bit en, input bit w);
        bus.rsData = 16'(rs);
        bus.offset = 4'(off);
        bus.rtData = 16'(rt);
        bus.enable = en;
        bus.wr     = w;
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 1'b1, 1'b0);
        clear_model();
        #3;
        vectors++;
        if (bus.data_out !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_hold_data: got %h want 0000", bus.data_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        vectors++;
        if (bus.target_addr !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_addr: got %h want 0000", bus.target_addr);
        end
        vectors++;
        if (bus.data_out !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_data: got %h want 0000", bus.data_out);
        end
    endtask

    task automatic test_addr_gen();
        int rs_t  [4] = '{32'h1001, 32'h0010, 32'h0000, 32'hFFFE};
        int off_t [4] = '{3, 15, 8, 1};
        int exp_t [4] = '{32'h1006, 32'h000E, 32'hFFF0, 32'h0000};
        for (int i = 0; i < 4; i++) begin
            drive(rs_t[i], off_t[i], 0, 1'b0, 1'b0);
            #1;
            vectors++;
            if (bus.target_addr !== 16'(exp_t[i])) begin
                miscompares++;
                $display("FAIL addr_gen_%0d: got %h want %h", i, bus.target_addr, 16'(exp_t[i]));
            end
        end
        for (int i = 0; i < 100; i++) begin
            int rs;
            int off;
            rs  = int'($urandom_range(0, 65535));
            off = int'($urandom_range(0, 15));
            drive(rs, off, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            #1;
            vectors++;
            if (bus.target_addr !== 16'(ref_addr(rs, off))) begin
                miscompares++;
                $display("FAIL addr_rand rs=%h off=%0d: got %h want %h", rs, off,
                         bus.target_addr, 16'(ref_addr(rs, off)));
            end
        end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        drive(16'h0006, 0, 16'hBEEF, 1'b1, 1'b1);
        #1;
        vectors++;
        if (bus.data_out !== 16'h0000) begin
            miscompares++;
            $display("FAIL read_during_write: got %h want 0000", bus.data_out);
        end
        @(posedge clk);
        ref_mem[3] = 16'hBEEF;
        #1;
        bus.wr = 1'b0;
        #1;
        vectors++;
        if (bus.data_out !== 16'hBEEF) begin
            miscompares++;
            $display("FAIL write_read: got %h want beef", bus.data_out);
        end
        bus.enable = 1'b0;
        #1;
        vectors++;
        if (bus.data_out !== 16'h0000) begin
            miscompares++;
            $display("FAIL read_disabled: got %h want 0000", bus.data_out);
        end
    endtask

    task automatic test_alias();
        drive(16'h0206, 0, 0, 1'b1, 1'b0);
        #1;
        vectors++;
        if (bus.data_out !== 16'hBEEF) begin
            miscompares++;
            $display("FAIL alias_read: got %h want beef", bus.data_out);
        end
        @(negedge clk);
        drive(16'h0008, 0, 16'h1234, 1'b1, 1'b1);
        @(posedge clk);
        ref_mem[4] = 16'h1234;
        #1;
        drive(16'h0006, 0, 0, 1'b1, 1'b0);
        #1;
        vectors++;
        if (bus.data_out !== 16'hBEEF) begin
            miscompares++;
            $display("FAIL neighbour_kept: got %h want beef", bus.data_out);
        end
        drive(16'h0008, 0, 0, 1'b1, 1'b0);
        #1;
        vectors++;
        if (bus.data_out !== 16'h1234) begin
            miscompares++;
            $display("FAIL second_word: got %h want 1234", bus.data_out);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            int rs;
            int off;
            int rt;
            bit en;
            bit w;
            @(negedge clk);
            rs  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 80));
            off = int'($urandom_range(0, 15));
            rt  = int'($urandom_range(0, 65535));
            en  = ($urandom_range(0, 3) != 0);
            w   = ($urandom_range(0, 2) == 0);
            drive(rs, off, rt, en, w);
            #1;
            vectors++;
            if (bus.target_addr !== 16'(ref_addr(rs, off)) ||
                bus.data_out !== 16'(ref_read(rs, off, en, w, 1'b1))) begin
                miscompares++;
                $display("FAIL random_op_%0d: got addr=%h data=%h want addr=%h data=%h", i,
                         bus.target_addr, bus.data_out, 16'(ref_addr(rs, off)),
                         16'(ref_read(rs, off, en, w, 1'b1)));
            end
            @(posedge clk);
            if (en && w) ref_mem[ref_idx(ref_addr(rs, off))] = rt;
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        drive(16'h0006, 0, 16'hBEEF, 1'b1, 1'b1);
        @(posedge clk);
        ref_mem[3] = 16'hBEEF;
        #1;
        bus.wr = 1'b0;
        #2;
        vectors++;
        if (bus.data_out !== 16'hBEEF) begin
            miscompares++;
            $display("FAIL pre_reset_data: got %h want beef", bus.data_out);
        end
        rst_n = 1'b0;
        clear_model();
        #1;
        vectors++;
        if (bus.data_out !== 16'h0000) begin
            miscompares++;
            $display("FAIL async_reset_data: got %h want 0000", bus.data_out);
        end
        bus.offset = 4'h1;
        #1;
        vectors++;
        if (bus.target_addr !== 16'h0008) begin
            miscompares++;
            $display("FAIL addr_in_reset: got %h want 0008", bus.target_addr);
        end
        drive(16'h000A, 0, 16'h5555, 1'b1, 1'b1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(16'h000A, 0, 0, 1'b1, 1'b0);
        #1;
        vectors++;
        if (bus.data_out !== 16'h0000) begin
            miscompares++;
            $display("FAIL write_blocked: got %h want 0000", bus.data_out);
        end
        drive(16'h0006, 0, 0, 1'b1, 1'b0);
        #1;
        vectors++;
        if (bus.data_out !== 16'(ref_mem[3])) begin
            miscompares++;
            $display("FAIL cleared_word: got %h want %h", bus.data_out, 16'(ref_mem[3]));
        end
        @(negedge clk);
        drive(16'h0006, 0, 16'hA5A5, 1'b1, 1'b1);
        @(posedge clk);
        ref_mem[3] = 16'hA5A5;
        #1;
        bus.wr = 1'b0;
        #1;
        vectors++;
        if (bus.data_out !== 16'hA5A5) begin
            miscompares++;
            $display("FAIL write_after_release: got %h want a5a5", bus.data_out);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_addr_gen();
        test_write_read();
        test_alias();
        test_random();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
